// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy encoding, per-boundary payload
// widths and control-field bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int FD_DATA_W = 64;
    localparam int FD_CTRL_W = 8;
    localparam int DE_DATA_W = 128;
    localparam int DE_CTRL_W = 8;
    localparam int EM_DATA_W = 128;
    localparam int EM_CTRL_W = 8;
    localparam int MW_DATA_W = 64;
    localparam int MW_CTRL_W = 8;

    // Control field layout: [0] memWrite, [1] regWrite, [2] resultSrc, [7:3] rd
    localparam int CTRL_MEMWRITE  = 0;
    localparam int CTRL_REGWRITE  = 1;
    localparam int CTRL_RESULTSRC = 2;
    localparam int CTRL_RD_LSB    = 3;
    localparam int CTRL_RD_W      = 5;

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One storage entry (valid/data/ctrl) with load and clear; clear always wins.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DE_DATA_W,
    parameter int CTRL_W     = DE_CTRL_W,
    parameter int RESET_DATA = 1
) (
    input  logic              clk,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end
    end

    // With RESET_DATA=0 the data field keeps its last value across a clear.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            if (RESET_DATA != 0) r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a main slot, a skid slot for full
// throughput under back-pressure, and a flush that leaves a bubble.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DE_DATA_W,
    parameter int CTRL_W     = DE_CTRL_W,
    parameter int RESET_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    occ_e r_state;
    occ_e w_state_nxt;

    logic              w_kill, w_acc, w_dep;
    logic              w_main_load, w_main_clear, w_skid_load, w_skid_clear;
    logic              w_main_valid, w_skid_valid;
    logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_din;
    logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_cin;

    assign w_kill = rst | flush;
    // in_ready is the inverted skid valid flop, so out_ready never reaches it.
    assign in_ready = ~w_skid_valid;
    assign w_acc    = in_valid & in_ready;
    assign w_dep    = w_main_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OCC_EMPTY: if (w_acc) w_state_nxt = OCC_ONE;
            OCC_ONE: begin
                if (w_acc && !w_dep)      w_state_nxt = OCC_FULL;
                else if (!w_acc && w_dep) w_state_nxt = OCC_EMPTY;
            end
            OCC_FULL:  if (w_dep) w_state_nxt = OCC_ONE;
            default:   w_state_nxt = OCC_EMPTY;
        endcase
        if (w_kill) w_state_nxt = OCC_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= OCC_EMPTY;
        else     r_state <= w_state_nxt;
    end

    assign w_main_load  = ((r_state == OCC_EMPTY) && w_acc)
                        | ((r_state == OCC_ONE)   && w_acc && w_dep)
                        | ((r_state == OCC_FULL)  && w_dep);
    assign w_main_clear = w_kill | ((r_state == OCC_ONE) && !w_acc && w_dep);
    assign w_skid_load  = (r_state == OCC_ONE) && w_acc && !w_dep;
    assign w_skid_clear = w_kill | ((r_state == OCC_FULL) && w_dep);

    // Draining FULL refills main from skid so the older entry is never overtaken.
    assign w_main_din = (r_state == OCC_FULL) ? w_skid_data : in_data;
    assign w_main_cin = (r_state == OCC_FULL) ? w_skid_ctrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_main (
        .clk     (clk),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_data  (w_main_din),
        .i_ctrl  (w_main_cin),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_skid (
        .clk     (clk),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    // A bubble must never present a write enable downstream.
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign occupancy = r_state;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_acc && (r_state == OCC_FULL)));
            assert (occupancy == occ_count(w_main_valid, w_skid_valid));
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid against a queue scoreboard.
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    logic          b_rst, b_flush, b_in_valid, b_out_ready;
    logic [DW-1:0] b_in_data;
    logic [CW-1:0] b_in_ctrl;
    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [CW-1:0] b_out_ctrl;
    logic [1:0]    b_occupancy;

    entry_t q[$];
    int     vectors = 0;
    int     miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .RESET_DATA(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .RESET_DATA(0)) dut_hold (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .occupancy(b_occupancy)
    );

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Drive one cycle; the scoreboard predicts from the handshake seen before the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy);
        entry_t e;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        #1;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {32'd0, out_data}, 64'hDEAD_0000_DEAD_0000);
                end else begin
                    e = q.pop_front();
                    chk("out_data", {32'd0, out_data}, {32'd0, e.d});
                    chk("out_ctrl", {56'd0, out_ctrl}, {56'd0, e.c});
                end
            end
            if (in_valid && in_ready) q.push_back('{d: d, c: c});
        end
        @(posedge clk);
        @(negedge clk);
        chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
        chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
        if (!out_valid) chk("bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
    endtask

    initial begin
        logic          rv;
        logic [DW-1:0] rd;
        logic [CW-1:0] rc;

        rst = 1'b1; flush = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_data = '0; b_in_ctrl = '0;

        // Reset held two cycles with a live input offered
        cycle(1'b1, 32'h5A, 8'hFF, 1'b0);
        cycle(1'b1, 32'h5A, 8'hFF, 1'b0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        b_rst = 1'b0;

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, DW'(i), CW'(8'h10 + i), 1'b1);
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_data", {32'd0, out_data}, 64'(i));
        end
        cycle(1'b0, 32'h0, 8'h0, 1'b1);
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // Back-pressure with A, B, C
        cycle(1'b1, 32'h10, 8'h03, 1'b0);
        cycle(1'b1, 32'h20, 8'h0B, 1'b0);
        chk("bp_hold_a", {32'd0, out_data}, 64'h10);
        chk("bp_full_occ", {62'd0, occupancy}, 64'd2);
        cycle(1'b1, 32'h30, 8'h13, 1'b0);
        chk("bp_c_refused_occ", {62'd0, occupancy}, 64'd2);
        chk("bp_still_a", {32'd0, out_data}, 64'h10);
        cycle(1'b1, 32'h30, 8'h13, 1'b1);
        chk("bp_b_out", {32'd0, out_data}, 64'h20);
        cycle(1'b1, 32'h30, 8'h13, 1'b1);
        chk("bp_c_out", {32'd0, out_data}, 64'h30);
        cycle(1'b0, 32'h0, 8'h0, 1'b1);
        chk("bp_empty_occ", {62'd0, occupancy}, 64'd0);

        // Flush while FULL, with a competing input
        cycle(1'b1, 32'h40, 8'h22, 1'b0);
        cycle(1'b1, 32'h50, 8'h33, 1'b0);
        chk("pre_flush_occ", {62'd0, occupancy}, 64'd2);
        flush = 1'b1;
        cycle(1'b1, 32'h99, 8'hFF, 1'b0);
        flush = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("flush_data", {32'd0, out_data}, 64'd0);
        chk("flush_occ", {62'd0, occupancy}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h99, 8'hFF, 1'b1);
            chk("flush_no_99", {63'd0, out_valid}, 64'd0);
        end

        // Bubble masking
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h77, 8'h41, 1'b1);
            chk("bubble_ctrl0", {56'd0, out_ctrl}, 64'd0);
            chk("bubble_valid0", {63'd0, out_valid}, 64'd0);
        end

        // Random traffic; upstream holds an offer until it is taken
        rv = 1'b0; rd = '0; rc = '0;
        for (int i = 0; i < 120; i++) begin
            if (!(rv && !in_ready)) begin
                rv = ($urandom_range(0, 3) != 0);
                rd = DW'($urandom);
                rc = CW'($urandom);
            end
            cycle(rv, rd, rc, ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 8'h0, 1'b1);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        // RESET_DATA=0 instance keeps data across flush
        b_in_valid = 1'b1; b_in_data = 32'hABCD; b_in_ctrl = 8'h41;
        @(posedge clk); @(negedge clk);
        b_in_valid = 1'b0;
        chk("hold_loaded_valid", {63'd0, b_out_valid}, 64'd1);
        chk("hold_loaded_data", {32'd0, b_out_data}, 64'hABCD);
        b_flush = 1'b1;
        @(posedge clk); @(negedge clk);
        b_flush = 1'b0;
        chk("hold_flush_valid", {63'd0, b_out_valid}, 64'd0);
        chk("hold_flush_ctrl", {56'd0, b_out_ctrl}, 64'd0);
        chk("hold_flush_data", {32'd0, b_out_data}, 64'hABCD);
        chk("hold_flush_occ", {62'd0, b_occupancy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
